// File: rtl/ex_mem_stage_if.sv
// EX->MEM boundary bundle: EX beat in, MEM beat out, flush and branch redirect.
// master drives the EX side and consumes the MEM side; slave is the stage.
interface ex_mem_stage_if #(
  parameter int XLEN = 32
);
  logic            ex_valid;
  logic            ex_ready;
  logic [XLEN-1:0] ALU_Result;
  logic            Zero;
  logic [4:0]      rd;
  logic            reg_write;
  logic            mem_read;
  logic            mem_write;
  logic            branch;
  logic [XLEN-1:0] store_data;
  logic [XLEN-1:0] branch_target;
  logic            flush;

  logic            mem_valid;
  logic            mem_ready;
  logic [XLEN-1:0] mem_alu_result;
  logic [XLEN-1:0] mem_store_data;
  logic [4:0]      mem_rd;
  logic            mem_reg_write;
  logic            mem_mem_read;
  logic            mem_mem_write;

  logic            pc_redirect;
  logic [XLEN-1:0] redirect_target;

  modport master (
    output ex_valid, ALU_Result, Zero, rd, reg_write, mem_read, mem_write,
           branch, store_data, branch_target, flush, mem_ready,
    input  ex_ready, mem_valid, mem_alu_result, mem_store_data, mem_rd,
           mem_reg_write, mem_mem_read, mem_mem_write, pc_redirect, redirect_target
  );

  modport slave (
    input  ex_valid, ALU_Result, Zero, rd, reg_write, mem_read, mem_write,
           branch, store_data, branch_target, flush, mem_ready,
    output ex_ready, mem_valid, mem_alu_result, mem_store_data, mem_rd,
           mem_reg_write, mem_mem_read, mem_mem_write, pc_redirect, redirect_target
  );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with one skid slot; 1-cycle latency, taken-branch redirect pulse.
// Backpressure: ex_ready is registered and drops only when both slots are full after the edge.
module ex_mem_stage #(
  parameter int XLEN = 32
) (
  input logic          clk,
  input logic          rst_n,
  ex_mem_stage_if.slave bus
);

  typedef struct packed {
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] store_data;
    logic [4:0]      rd;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
  } beat_t;

  beat_t           out_q, out_d, skid_q, skid_d, in_beat;
  logic            out_vld_q, out_vld_d;
  logic            skid_vld_q, skid_vld_d;
  logic            ex_ready_q, ex_ready_d;
  logic            redirect_q, redirect_d;
  logic [XLEN-1:0] target_q, target_d;
  logic            accept, xfer;

  assign accept = bus.ex_valid & ex_ready_q;
  assign xfer   = out_vld_q & bus.mem_ready;

  // Branches never write back or touch memory, taken or not.
  always_comb begin
    in_beat            = '0;
    in_beat.alu_result = bus.ALU_Result;
    in_beat.store_data = bus.store_data;
    in_beat.rd         = bus.rd;
    in_beat.reg_write  = bus.reg_write & ~bus.branch;
    in_beat.mem_read   = bus.mem_read  & ~bus.branch;
    in_beat.mem_write  = bus.mem_write & ~bus.branch;
  end

  always_comb begin
    out_d      = out_q;
    out_vld_d  = out_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    redirect_d = 1'b0;
    target_d   = target_q;
    if (bus.flush) begin
      out_vld_d  = 1'b0;
      skid_vld_d = 1'b0;
    end else begin
      if (xfer) begin
        if (skid_vld_q) begin
          out_d      = skid_q;
          skid_vld_d = 1'b0;
        end else begin
          out_vld_d = 1'b0;
        end
      end
      // Fill OUT first if it is free after the drain, otherwise park in SKID.
      if (accept) begin
        if (!out_vld_d) begin
          out_d     = in_beat;
          out_vld_d = 1'b1;
        end else begin
          skid_d     = in_beat;
          skid_vld_d = 1'b1;
        end
        if (bus.branch && bus.Zero) begin
          redirect_d = 1'b1;
          target_d   = bus.branch_target;
        end
      end
    end
    ex_ready_d = ~(out_vld_d & skid_vld_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q      <= '0;
      out_vld_q  <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
      ex_ready_q <= 1'b0;
      redirect_q <= 1'b0;
      target_q   <= '0;
    end else begin
      out_q      <= out_d;
      out_vld_q  <= out_vld_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
      ex_ready_q <= ex_ready_d;
      redirect_q <= redirect_d;
      target_q   <= target_d;
    end
  end

  assign bus.ex_ready        = ex_ready_q;
  assign bus.mem_valid       = out_vld_q;
  assign bus.mem_alu_result  = out_q.alu_result;
  assign bus.mem_store_data  = out_q.store_data;
  assign bus.mem_rd          = out_q.rd;
  assign bus.mem_reg_write   = out_q.reg_write;
  assign bus.mem_mem_read    = out_q.mem_read;
  assign bus.mem_mem_write   = out_q.mem_write;
  assign bus.pc_redirect     = redirect_q;
  assign bus.redirect_target = target_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: vector table through a scoreboard, plus hand-built stall/flush/reset sequences.
module tb_ex_mem_stage;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  ex_mem_stage_if #(.XLEN(32)) bus ();

  ex_mem_stage #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] store;
    logic [31:0] tgt;
    logic [4:0]  rd;
    logic        zero, br, rw, mr, mw;
    logic        exp_rw, exp_mr, exp_mw, exp_redir;
  } vec_t;

  vec_t        tv [8];
  logic [71:0] sb [$];

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] alu, input logic [31:0] store, input logic [31:0] tgt,
                       input logic [4:0] rd, input logic zero, input logic br,
                       input logic rw, input logic mr, input logic mw);
    bus.ex_valid      = 1'b1;
    bus.ALU_Result    = alu;
    bus.store_data    = store;
    bus.branch_target = tgt;
    bus.rd            = rd;
    bus.Zero          = zero;
    bus.branch        = br;
    bus.reg_write     = rw;
    bus.mem_read      = mr;
    bus.mem_write     = mw;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 20 && sb.size() != 0; k++) step();
    chk("drain_left", 80'(sb.size()), 80'd0);
  endtask

  // Each MEM-side transfer must match the oldest outstanding expected beat.
  always @(negedge clk) begin
    if (rst_n && bus.mem_valid && bus.mem_ready) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_beat: got alu %0h expected none", bus.mem_alu_result);
      end else begin
        chk("mem_beat", 80'({bus.mem_alu_result, bus.mem_store_data, bus.mem_rd,
                             bus.mem_reg_write, bus.mem_mem_read, bus.mem_mem_write}),
            80'(sb.pop_front()));
      end
    end
  end

  initial begin
    n_pass  = 0;
    n_total = 0;
    tv[0] = '{32'h10, 32'h1, 32'h0, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[1] = '{32'h20, 32'h2, 32'h0, 5'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[2] = '{32'h30, 32'h3, 32'h0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tv[3] = '{32'h40, 32'h4, 32'h100, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tv[4] = '{32'h50, 32'h5, 32'h180, 5'd5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[5] = '{32'h60, 32'h6, 32'h200, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tv[6] = '{32'h70, 32'h7, 32'h300, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tv[7] = '{32'h80, 32'hDEADBEEF, 32'h0, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    rst_n = 1'b0;
    drive(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.ex_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.mem_ready = 1'b1;

    // Reset state, held across an edge.
    #12;
    chk("rst_mem_valid", 80'(bus.mem_valid), 80'd0);
    chk("rst_ex_ready", 80'(bus.ex_ready), 80'd0);
    chk("rst_pc_redirect", 80'(bus.pc_redirect), 80'd0);
    chk("rst_data", 80'({bus.mem_alu_result, bus.mem_store_data, bus.mem_rd}), 80'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_ex_ready_pre", 80'(bus.ex_ready), 80'd0);
    step();
    chk("rel_ex_ready_post", 80'(bus.ex_ready), 80'd1);

    // Table: pass-through, taken / not-taken / back-to-back branches.
    for (int i = 0; i < 8; i++) begin
      drive(tv[i].alu, tv[i].store, tv[i].tgt, tv[i].rd, tv[i].zero, tv[i].br,
            tv[i].rw, tv[i].mr, tv[i].mw);
      chk("pt_ex_ready", 80'(bus.ex_ready), 80'd1);
      sb.push_back({tv[i].alu, tv[i].store, tv[i].rd, tv[i].exp_rw, tv[i].exp_mr, tv[i].exp_mw});
      step();
      chk("pt_redirect", 80'(bus.pc_redirect), 80'(tv[i].exp_redir));
      if (tv[i].exp_redir) chk("pt_target", 80'(bus.redirect_target), 80'(tv[i].tgt));
    end
    bus.ex_valid = 1'b0;
    step();
    chk("pt_redirect_end", 80'(bus.pc_redirect), 80'd0);
    wait_drain();

    // Backpressure fills OUT then SKID, then drains in order.
    bus.mem_ready = 1'b0;
    drive(32'hA, 32'h0, 32'h0, 5'd10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    sb.push_back({32'hA, 32'h0, 5'd10, 1'b1, 1'b0, 1'b0});
    step();
    chk("bp_ready_occ1", 80'(bus.ex_ready), 80'd1);
    drive(32'hB, 32'h0, 32'h0, 5'd11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    sb.push_back({32'hB, 32'h0, 5'd11, 1'b1, 1'b0, 1'b0});
    step();
    bus.ex_valid = 1'b0;
    chk("bp_out", 80'(bus.mem_alu_result), 80'hA);
    chk("bp_valid", 80'(bus.mem_valid), 80'd1);
    chk("bp_ready_full", 80'(bus.ex_ready), 80'd0);
    step();
    chk("bp_out_held", 80'(bus.mem_alu_result), 80'hA);
    chk("bp_ready_held", 80'(bus.ex_ready), 80'd0);
    bus.mem_ready = 1'b1;
    step();
    chk("bp_ready_back", 80'(bus.ex_ready), 80'd1);
    chk("bp_out_next", 80'(bus.mem_alu_result), 80'hB);
    wait_drain();
    chk("bp_ready_idle", 80'(bus.ex_ready), 80'd1);

    // Flush while full; the offered taken branch is not accepted anyway.
    bus.mem_ready = 1'b0;
    drive(32'hC, 32'h0, 32'h0, 5'd12, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    sb.push_back({32'hC, 32'h0, 5'd12, 1'b1, 1'b0, 1'b0});
    step();
    drive(32'hD, 32'h0, 32'h0, 5'd13, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    sb.push_back({32'hD, 32'h0, 5'd13, 1'b1, 1'b0, 1'b0});
    step();
    drive(32'hE, 32'h0, 32'h400, 5'd14, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    bus.flush = 1'b1;
    sb.delete();
    step();
    bus.flush    = 1'b0;
    bus.ex_valid = 1'b0;
    chk("fl2_mem_valid", 80'(bus.mem_valid), 80'd0);
    chk("fl2_redirect", 80'(bus.pc_redirect), 80'd0);
    chk("fl2_ex_ready", 80'(bus.ex_ready), 80'd1);

    // Flush with a real same-cycle taken-branch accept: accept and pulse both dropped.
    drive(32'hF, 32'h0, 32'h0, 5'd15, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    sb.push_back({32'hF, 32'h0, 5'd15, 1'b1, 1'b0, 1'b0});
    step();
    drive(32'h11, 32'h0, 32'h440, 5'd16, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    bus.flush = 1'b1;
    sb.delete();
    step();
    bus.flush    = 1'b0;
    bus.ex_valid = 1'b0;
    chk("fl1_mem_valid", 80'(bus.mem_valid), 80'd0);
    chk("fl1_redirect", 80'(bus.pc_redirect), 80'd0);
    chk("fl1_ex_ready", 80'(bus.ex_ready), 80'd1);
    step();
    chk("fl1_redirect_late", 80'(bus.pc_redirect), 80'd0);

    // A pulse already high survives a flush in its own cycle.
    drive(32'h12, 32'h0, 32'h500, 5'd17, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    bus.ex_valid = 1'b0;
    bus.flush    = 1'b1;
    #1;
    chk("flr_redirect", 80'(bus.pc_redirect), 80'd1);
    chk("flr_target", 80'(bus.redirect_target), 80'h500);
    step();
    bus.flush = 1'b0;
    chk("flr_redirect_done", 80'(bus.pc_redirect), 80'd0);
    chk("flr_mem_valid", 80'(bus.mem_valid), 80'd0);

    // Asynchronous reset mid-cycle with both slots full.
    drive(32'h21, 32'h0, 32'h0, 5'd18, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    sb.push_back({32'h21, 32'h0, 5'd18, 1'b1, 1'b0, 1'b0});
    step();
    drive(32'h22, 32'h0, 32'h0, 5'd19, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    sb.push_back({32'h22, 32'h0, 5'd19, 1'b1, 1'b0, 1'b0});
    step();
    bus.ex_valid = 1'b0;
    chk("ar_full", 80'(bus.ex_ready), 80'd0);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("ar_mem_valid", 80'(bus.mem_valid), 80'd0);
    chk("ar_ex_ready", 80'(bus.ex_ready), 80'd0);
    chk("ar_data", 80'(bus.mem_alu_result), 80'd0);
    #10;
    rst_n = 1'b1;
    bus.mem_ready = 1'b1;
    #1;
    chk("ar_ready_pre", 80'(bus.ex_ready), 80'd0);
    step();
    chk("ar_ready_post", 80'(bus.ex_ready), 80'd1);
    chk("ar_no_pulse", 80'(bus.pc_redirect), 80'd0);
    chk("ar_empty", 80'(bus.mem_valid), 80'd0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
